// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master for a single-port on-chip RAM (read latency 1).
// Copies a block from one word address to another, or fills a block with a constant pattern.
module onchip_mem_copy_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                pause,
    output logic                busy,
    output logic                done,
    output logic [LEN_W-1:0]    xfer_count,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    // state | meaning
    // IDLE  | waiting for start
    // RD    | read access at src pointer
    // LAT   | no access; capture readdata into buf
    // WR    | write buf to dst pointer
    // FW    | write fill pattern to dst pointer
    // FIN   | command finished; done pulses on the following cycle
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LAT, S_WR, S_FW, S_FIN
    } state_t;

    localparam int BE_W = DATA_W / 8;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    state_t              state_q, state_d;
    logic                act_q, act_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]    rem_q, rem_d, cnt_q, cnt_d;
    logic [DATA_W-1:0]   fill_q, fill_d, buf_q, buf_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                cs_q, cs_d, we_q, we_d, clken_q, clken_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // act_q says whether the current state's action really happens this cycle;
    // it is cleared for cycles in which pause was sampled high.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    fill_d = fill_data;
                    cnt_d  = '0;
                    rem_d  = (len > MAX_LEN) ? MAX_LEN : len;
                    if (len == '0)  state_d = S_FIN;
                    else if (mode)  state_d = S_FW;
                    else            state_d = S_RD;
                end
            end
            S_RD: if (act_q) state_d = S_LAT;
            S_LAT: begin
                if (act_q) begin
                    buf_d   = readdata;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (act_q) begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    cnt_d   = cnt_q + LEN_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_RD;
                end
            end
            S_FW: begin
                if (act_q) begin
                    dst_d   = dst_q + ADDR_W'(1);
                    cnt_d   = cnt_q + LEN_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_FW;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        act_d   = !(pause && (state_d inside {S_RD, S_LAT, S_WR, S_FW}));
        cs_d    = act_d && (state_d inside {S_RD, S_WR, S_FW});
        we_d    = cs_d && (state_d != S_RD);
        addr_d  = '0;
        wdata_d = '0;
        if (cs_d) addr_d = (state_d == S_RD) ? src_d : dst_d;
        if (we_d) wdata_d = (state_d == S_FW) ? fill_d : buf_d;
        be_d    = cs_d ? '1 : '0;
        clken_d = act_d;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            clken_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            clken_q <= clken_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_count = cnt_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign chipselect = cs_q;
    assign write      = we_q;
    assign writedata  = wdata_q;
    assign clken      = clken_q;

endmodule

// File: tb/tb_onchip_mem_copy_master.sv
// Directed bench for onchip_mem_copy_master with a behavioural 1024x32 RAM (read latency 1).
module tb_onchip_mem_copy_master;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] fill_data = '0;
    logic          busy, done, chipselect, write, clken;
    logic [LW-1:0] xfer_count;
    logic [AW-1:0] address;
    logic [DW/8-1:0] byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] rdata;

    logic          clr = 1'b0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] mem [0:1023];

    int n_chk = 0;
    int n_err = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_bad = 0;
    int lat, rd0, wr0;

    always #5 clk = ~clk;

    onchip_mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .pause(pause), .busy(busy), .done(done), .xfer_count(xfer_count),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .clken(clken), .readdata(rdata)
    );

    always @(posedge clk) begin
        if (!chipselect && write) n_bad = n_bad + 1;
        if (chipselect && (!clken || byteenable != '1)) n_bad = n_bad + 1;
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] = '0;
        end else if (pre_we) begin
            mem[pre_addr] = pre_data;
        end else if (clken && chipselect) begin
            if (write) begin
                mem[address] = writedata;
                n_wr = n_wr + 1;
            end else begin
                rdata <= mem[address];
                n_rd = n_rd + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l, input logic [DW-1:0] f);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rdata = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        preload(10'h010, 32'h11111111);
        preload(10'h011, 32'h22222222);
        preload(10'h012, 32'h33333333);
        preload(10'h013, 32'h44444444);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_clken", clken, 0);
        chk("rst_outs", {xfer_count, address, byteenable, write, writedata}, 0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_clken", clken, 1);

        // fill across the top of memory
        rd0 = n_rd; wr0 = n_wr;
        issue(1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEADBEEF);
        chk("fill_busy", busy, 1);
        chk("fill_addr0", address, 10'h3FE);
        wait_done(1, lat);
        chk("fill_lat", lat, 6);
        chk("fill_busy_done", busy, 0);
        chk("fill_xfer", xfer_count, 4);
        tick();
        chk("fill_done_pulse", done, 0);
        chk("fill_xfer_hold", xfer_count, 4);
        chk("fill_m3fe", mem[10'h3FE], 32'hDEADBEEF);
        chk("fill_m3ff", mem[10'h3FF], 32'hDEADBEEF);
        chk("fill_m000", mem[10'h000], 32'hDEADBEEF);
        chk("fill_m001", mem[10'h001], 32'hDEADBEEF);
        chk("fill_m002", mem[10'h002], 0);
        chk("fill_acc", {n_rd - rd0, n_wr - wr0}, {32'd0, 32'd4});

        // four-word copy
        rd0 = n_rd; wr0 = n_wr;
        issue(1'b0, 10'h010, 10'h200, 11'd4, 32'h0);
        chk("copy_rd_addr", {chipselect, write, address}, {1'b1, 1'b0, 10'h010});
        wait_done(1, lat);
        chk("copy_lat", lat, 14);
        chk("copy_xfer", xfer_count, 4);
        chk("copy_m200", mem[10'h200], 32'h11111111);
        chk("copy_m201", mem[10'h201], 32'h22222222);
        chk("copy_m202", mem[10'h202], 32'h33333333);
        chk("copy_m203", mem[10'h203], 32'h44444444);
        chk("copy_acc", {n_rd - rd0, n_wr - wr0}, {32'd4, 32'd4});

        // zero length in both modes; the second one with pause held in IDLE
        rd0 = n_rd; wr0 = n_wr;
        issue(1'b0, 10'h010, 10'h220, 11'd0, 32'h0);
        chk("len0c_cs", chipselect, 0);
        wait_done(1, lat);
        chk("len0c_lat", lat, 2);
        chk("len0c_xfer", xfer_count, 0);
        tick();
        pause = 1'b1;
        issue(1'b1, 10'h000, 10'h220, 11'd0, 32'hFFFFFFFF);
        pause = 1'b0;
        wait_done(1, lat);
        chk("len0f_lat", lat, 2);
        chk("len0_acc", {n_rd - rd0, n_wr - wr0}, 64'd0);
        chk("len0_m220", mem[10'h220], 0);
        tick();

        // start while busy is ignored
        issue(1'b1, 10'h000, 10'h100, 11'd5, 32'hA5A5A5A5);
        tick();
        mode = 1'b1; dst_addr = 10'h140; len = 11'd1; fill_data = 32'h12345678;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3, lat);
        chk("busy_lat", lat, 7);
        chk("busy_xfer", xfer_count, 5);
        chk("busy_m104", mem[10'h104], 32'hA5A5A5A5);
        chk("busy_m140", mem[10'h140], 0);
        tick();

        // pause held across the read latency cycle
        issue(1'b0, 10'h010, 10'h300, 11'd1, 32'h0);
        chk("pause_rd", {chipselect, write}, 2'b10);
        pause = 1'b1;
        tick();
        chk("pause_clken", clken, 0);
        chk("pause_cs", chipselect, 0);
        chk("pause_busy", busy, 1);
        tick();
        tick();
        pause = 1'b0;
        wait_done(4, lat);
        chk("pause_lat", lat, 8);
        chk("pause_m300", mem[10'h300], 32'h11111111);
        tick();

        // reset asserted during the write of the second word
        issue(1'b0, 10'h010, 10'h380, 11'd4, 32'h0);
        repeat (5) tick();
        chk("rstmid_wr", {chipselect, write, address}, {1'b1, 1'b1, 10'h381});
        reset_n = 1'b0;
        #1;
        chk("rstmid_cs", {chipselect, write, clken, busy}, 4'b0000);
        chk("rstmid_wdata", writedata, 0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rstmid_busy", busy, 0);
        chk("rstmid_m380", mem[10'h380], 32'h11111111);
        chk("rstmid_m381", mem[10'h381], 0);
        chk("rstmid_m382", mem[10'h382], 0);
        chk("rstmid_m383", mem[10'h383], 0);

        // oversized length saturates to the full memory
        wr0 = n_wr;
        issue(1'b1, 10'h000, 10'h005, 11'h7FF, 32'h5A5A0000);
        wait_done(1, lat);
        chk("sat_lat", lat, 1026);
        chk("sat_xfer", xfer_count, 11'h400);
        chk("sat_wr", n_wr - wr0, 1024);
        chk("sat_m004", mem[10'h004], 32'h5A5A0000);
        chk("sat_m3ff", mem[10'h3FF], 32'h5A5A0000);

        chk("bus_rules", n_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
